// File: rtl/serial_deser_pkg.sv
// Shared constants and helpers for the serial sum deserializer.
// Latency: none, compile-time content only.
// Backpressure: not applicable.
package serial_deser_pkg;

  localparam int DEFAULT_W = 16;

  // Bit-counter width: ceil(log2(w)), never less than one bit.
  function automatic int cnt_width(input int w);
    int c;
    c = $clog2(w);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/word_hold_reg.sv
// One-entry valid/ready holding register; drops and flags words that find it full.
// Latency: a loaded word is visible on the outputs the cycle after load_i.
// Backpressure: none upstream; a load into a full, non-draining register is dropped and sets overflow_o.
module word_hold_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         out_ready_i,
  input  logic         sticky_clr_i,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  output logic         overflow_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         ovf_q, ovf_d;
  logic         can_load;
  logic         drop;

  // Empty or draining this cycle means the slot is free for a new word.
  assign can_load = !valid_q || out_ready_i;
  assign drop     = load_i && !can_load;

  // Load / drain / drop decision and sticky overflow with set-over-clear priority.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    if (load_i && can_load) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end else if (sticky_clr_i) begin
      ovf_d = 1'b0;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign overflow_o  = ovf_q;

endmodule

// File: rtl/serial_sum_deserializer.sv
// Collects an LSB-first serial sum stream into W-bit words on a valid/ready output.
// Latency: out_valid rises on the edge capturing the last bit of a word.
// Backpressure: serial input never stalls; a word arriving while the holding register is full is dropped and overflow is set.
// Optional: SERIAL_DESER_PARITY_EN adds out_parity, the XOR of out_data.
module serial_sum_deserializer
  import serial_deser_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         in_bit,
  input  logic         in_first,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         overflow,
  input  logic         sticky_clr
`ifdef SERIAL_DESER_PARITY_EN
  ,
  output logic         out_parity
`endif
);

  localparam int CNT_W = cnt_width(W);

`ifdef SERIAL_DESER_PARITY_EN
  localparam int HW = W + 1;
`else
  localparam int HW = W;
`endif

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             complete;
  logic [W-1:0]     word;
  logic [HW-1:0]    hold_in;
  logic [HW-1:0]    hold_out;

  // A word completes on its last bit; an in_first bit only completes when words are one bit wide.
  assign complete = in_valid && (in_first ? (W == 1) : (cnt_q == CNT_W'(W - 1)));

  // Bit counter: restarts at 1 on in_first, wraps to 0 on completion.
  always_comb begin
    cnt_d = cnt_q;
    if (in_valid) begin
      if (complete) begin
        cnt_d = '0;
      end else if (in_first) begin
        cnt_d = CNT_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Only the upper W-1 bit positions are stored; the incoming bit fills the MSB of
  // the completed word directly. Stale bits from a discarded partial word are
  // shifted out before they could reach a completed word.
  generate
    if (W == 1) begin : g_w1
      assign word = in_bit;
    end else begin : g_wn
      logic [W-2:0] shreg_q;

      assign word = {in_bit, shreg_q};

      // Shift register: new bits enter at the MSB end.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          shreg_q <= '0;
        end else if (in_valid) begin
          shreg_q <= word[W-1:1];
        end
      end
    end
  endgenerate

`ifdef SERIAL_DESER_PARITY_EN
  logic par_q, par_d;
  logic word_par;

  // Running XOR restarts with the bit-0 value on in_first.
  assign word_par = (in_first ? 1'b0 : par_q) ^ in_bit;

  // Running parity: cleared on completion, otherwise accumulates accepted bits.
  always_comb begin
    par_d = par_q;
    if (in_valid) begin
      par_d = complete ? 1'b0 : word_par;
    end
  end

  // Running parity register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign hold_in    = {word_par, word};
  assign out_parity = hold_out[W];
`else
  assign hold_in = word;
`endif

  word_hold_reg #(
    .W (HW)
  ) u_hold (
    .clk          (clk),
    .rst          (rst),
    .load_i       (complete),
    .data_i       (hold_in),
    .out_ready_i  (out_ready),
    .sticky_clr_i (sticky_clr),
    .out_valid_o  (out_valid),
    .out_data_o   (hold_out),
    .overflow_o   (overflow)
  );

  assign out_data = hold_out[W-1:0];

endmodule

// File: tb/tb_serial_sum_deserializer.sv
// Scoreboard bench for serial_sum_deserializer at W=8.
// Latency: expects each word the cycle after its last bit edge.
// Backpressure: exercised via out_ready, drop/overflow and simultaneous drain+load.
module tb_serial_sum_deserializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_bit;
  logic         in_first;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         overflow;
  logic         sticky_clr;
`ifdef SERIAL_DESER_PARITY_EN
  logic         out_parity;
`endif

  int tests = 0;
  int fails = 0;

  // Expected entries: {parity, data}
  logic [W:0] exp_q[$];

  serial_sum_deserializer #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .in_first   (in_first),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .overflow   (overflow),
    .sticky_clr (sticky_clr)
`ifdef SERIAL_DESER_PARITY_EN
    ,
    .out_parity (out_parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: handshakes are stable at the falling edge, ahead of the capturing rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL mon_unexpected: got word %0h expected no word", out_data);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        chk("mon_data", 64'(out_data), 64'(e[W-1:0]));
`ifdef SERIAL_DESER_PARITY_EN
        chk("mon_parity", 64'(out_parity), 64'(e[W]));
`endif
      end
    end
  end

  // One serial bit; returns just after the capturing edge.
  task automatic send_bit(input logic b, input logic f);
    in_valid = 1'b1;
    in_bit   = b;
    in_first = f;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input logic [W-1:0] w);
    exp_q.push_back({^w, w});
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit push);
    if (push) push_exp(w);
    for (int i = 0; i < W; i++) send_bit(w[i], i == 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_first = 1'b0;
    out_ready = 1'b1; sticky_clr = 1'b0;
    #12;
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_data", 64'(out_data), 64'd0);
    chk("reset_overflow", 64'(overflow), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // 1: basic assembly of 0x5A, valid for exactly one cycle
    send_word(8'h5A, 1'b1);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_data", 64'(out_data), 64'h5A);
    idle(1);
    chk("t1_valid_drop", 64'(out_valid), 64'd0);
    chk("t1_overflow", 64'(overflow), 64'd0);

    // 2: gaps between bits 2 and 3
    send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    idle(3);
    chk("t2_no_early_valid_gap", 64'(out_valid), 64'd0);
    send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    chk("t2_no_early_valid", 64'(out_valid), 64'd0);
    push_exp(8'h5A);
    send_bit(1'b0, 1'b0);
    chk("t2_valid", 64'(out_valid), 64'd1);
    chk("t2_data", 64'(out_data), 64'h5A);
    idle(1);

    // 3: backpressure drop; overflow set wins over a same-cycle sticky_clr
    out_ready = 1'b0;
    send_word(8'h0F, 1'b1);
    for (int i = 0; i < W - 1; i++) send_bit(1'(8'hA5 >> i), i == 0);
    sticky_clr = 1'b1;
    send_bit(1'b1, 1'b0);
    sticky_clr = 1'b0;
    chk("t3_held_data", 64'(out_data), 64'h0F);
    chk("t3_overflow_set", 64'(overflow), 64'd1);
    out_ready = 1'b1;
    idle(1);
    chk("t3_drained", 64'(out_valid), 64'd0);
    chk("t3_overflow_sticky", 64'(overflow), 64'd1);
    sticky_clr = 1'b1;
    idle(1);
    sticky_clr = 1'b0;
    chk("t3_overflow_clr", 64'(overflow), 64'd0);

    // 4: simultaneous drain and load
    out_ready = 1'b0;
    send_word(8'h11, 1'b1);
    push_exp(8'h22);
    for (int i = 0; i < W - 1; i++) send_bit(1'(8'h22 >> i), i == 0);
    out_ready = 1'b1;
    send_bit(1'b0, 1'b0);
    chk("t4_data", 64'(out_data), 64'h22);
    chk("t4_valid", 64'(out_valid), 64'd1);
    chk("t4_overflow", 64'(overflow), 64'd0);
    idle(1);

    // 5: resync after 5 bits, and in_first colliding with a would-be completion
    for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0);
    send_word(8'h3C, 1'b1);
    chk("t5_data", 64'(out_data), 64'h3C);
    idle(1);
    for (int i = 0; i < W - 1; i++) send_bit(1'b1, i == 0);
    send_word(8'h81, 1'b1);
    chk("t5_collide_data", 64'(out_data), 64'h81);
    chk("t5_overflow", 64'(overflow), 64'd0);
    idle(1);

    // 6: asynchronous reset mid-word with a held word and overflow set
    out_ready = 1'b0;
    send_word(8'h33, 1'b0);
    send_word(8'h44, 1'b0);
    chk("t6_pre_overflow", 64'(overflow), 64'd1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, i == 0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_data", 64'(out_data), 64'd0);
    chk("t6_rst_overflow", 64'(overflow), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send_word(8'h5A, 1'b1);
    chk("t6_data", 64'(out_data), 64'h5A);
`ifdef SERIAL_DESER_PARITY_EN
    chk("t6_parity_5a", 64'(out_parity), 64'd0);
`endif
    idle(1);
    send_word(8'h07, 1'b1);
    chk("t6_data_07", 64'(out_data), 64'h07);
`ifdef SERIAL_DESER_PARITY_EN
    chk("t6_parity_07", 64'(out_parity), 64'd1);
`endif
    idle(1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
